// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: valid/ready pipeline stage register with a 2-entry skid buffer and flush-to-bubble.
//   clk       in   clock
//   rstn      in   asynchronous active-low reset
//   flush     in   synchronous kill of all held entries (input dropped)
//   in_valid  in   upstream offers {ctl_in, ir_in, data_in}
//   in_ready  out  stage can accept (registered-state decode only)
//   out_valid out  head entry valid
//   out_ready in   downstream accepts head entry
//   ctl_out / ir_out / data_out  head entry, bubble values when !out_valid
//   stall_cnt out  (only with PIPE_STALL_CNT_EN) saturating count of out_valid && !out_ready cycles
module pipe_stage_skid #(
    parameter int          CTL_W  = 32,
    parameter int          DATA_W = 96,
    parameter logic [31:0] NOP_IR = 32'h0000_0033
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTL_W-1:0]  ctl_in,
    input  logic [31:0]       ir_in,
    input  logic [DATA_W-1:0] data_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTL_W-1:0]  ctl_out,
    output logic [31:0]       ir_out,
    output logic [DATA_W-1:0] data_out
`ifdef PIPE_STALL_CNT_EN
    ,
    output logic [31:0]       stall_cnt
`endif
);
    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;
    typedef struct packed {
        logic [CTL_W-1:0]  ctl;
        logic [31:0]       ir;
        logic [DATA_W-1:0] data;
    } entry_t;
    localparam entry_t BUBBLE = '{ctl: '0, ir: NOP_IR, data: '0};
    state_t state, state_n;
    entry_t head, skid, in_entry;
    logic   accept, retire, ld_head_in, ld_head_skid, ld_skid;
    assign in_entry  = '{ctl: ctl_in, ir: ir_in, data: data_in};
    assign in_ready  = (state != TWO);
    assign out_valid = (state != EMPTY);
    assign accept    = in_valid && in_ready;
    assign retire    = out_valid && out_ready;
    always_comb begin
        state_n      = state;
        ld_head_in   = 1'b0;
        ld_head_skid = 1'b0;
        ld_skid      = 1'b0;
        if (flush) begin
            state_n = EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    state_n    = accept ? ONE : EMPTY;
                    ld_head_in = accept;
                end
                ONE: begin
                    state_n    = accept ? (retire ? ONE : TWO) : (retire ? EMPTY : ONE);
                    ld_head_in = accept && retire;
                    ld_skid    = accept && !retire;
                end
                TWO: begin
                    state_n      = retire ? ONE : TWO;
                    ld_head_skid = retire;
                end
                default: state_n = EMPTY;
            endcase
        end
    end
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= EMPTY;
        else       state <= state_n;
    end
    // Flush also scrubs storage so no stale entry can resurface later.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            head <= BUBBLE;
            skid <= BUBBLE;
        end else if (flush) begin
            head <= BUBBLE;
            skid <= BUBBLE;
        end else begin
            if (ld_head_in)        head <= in_entry;
            else if (ld_head_skid) head <= skid;
            if (ld_skid)           skid <= in_entry;
        end
    end
    // Downstream decode must see a NOP whenever the stage is empty.
    assign ctl_out  = out_valid ? head.ctl  : BUBBLE.ctl;
    assign ir_out   = out_valid ? head.ir   : BUBBLE.ir;
    assign data_out = out_valid ? head.data : BUBBLE.data;
`ifdef PIPE_STALL_CNT_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)                                           stall_cnt <= '0;
        else if (out_valid && !out_ready && stall_cnt != '1) stall_cnt <= stall_cnt + 32'd1;
    end
`else
    // Stall counting is not built in this configuration.
`endif
endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb_pipe_stage_skid: directed self-checking bench for pipe_stage_skid.
module tb_pipe_stage_skid;
    localparam logic [31:0] NOP = 32'h0000_0033;
    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] ctl_in = '0;
    logic [31:0] ir_in = '0;
    logic [95:0] data_in = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] ctl_out;
    logic [31:0] ir_out;
    logic [95:0] data_out;
`ifdef PIPE_STALL_CNT_EN
    logic [31:0] stall_cnt;
`endif
    int checks = 0;
    int errors = 0;

    pipe_stage_skid dut (
        .clk(clk), .rstn(rstn), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .ctl_in(ctl_in), .ir_in(ir_in), .data_in(data_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .ctl_out(ctl_out), .ir_out(ir_out), .data_out(data_out)
`ifdef PIPE_STALL_CNT_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic [31:0] ir, input logic [31:0] ctl);
        in_valid = v;
        ir_in    = ir;
        ctl_in   = ctl;
        data_in  = {64'h0, ir};
    endtask

    initial begin
        // reset held 3 cycles with in_valid asserted
        drive(1'b1, 32'h0010_0093, 32'h5);
        for (int i = 0; i < 3; i++) begin
            smp();
            chk("rst_out_valid", 128'(out_valid), 128'(0));
            chk("rst_in_ready", 128'(in_ready), 128'(1));
            chk("rst_ir_out", 128'(ir_out), 128'(NOP));
            chk("rst_ctl_out", 128'(ctl_out), 128'(0));
            cyc();
        end
        drive(1'b0, 32'h0, 32'h0);
        rstn = 1'b1;
        cyc();

        // streaming with out_ready = 1
        out_ready = 1'b1;
        drive(1'b1, 32'h0010_0093, 32'h1);
        cyc();
        drive(1'b1, 32'h0020_0113, 32'h2);
        smp();
        chk("str1_valid", 128'(out_valid), 128'(1));
        chk("str1_ir", 128'(ir_out), 128'(32'h0010_0093));
        chk("str1_ready", 128'(in_ready), 128'(1));
        cyc();
        drive(1'b1, 32'h0030_0193, 32'h3);
        smp();
        chk("str2_valid", 128'(out_valid), 128'(1));
        chk("str2_ir", 128'(ir_out), 128'(32'h0020_0113));
        cyc();
        drive(1'b0, 32'hDEAD_BEEF, 32'h77);
        smp();
        chk("str3_valid", 128'(out_valid), 128'(1));
        chk("str3_ir", 128'(ir_out), 128'(32'h0030_0193));
        chk("str3_ctl", 128'(ctl_out), 128'(3));
        chk("str3_data", 128'(data_out), 128'({64'h0, 32'h0030_0193}));
        cyc();
        smp();
        chk("str_end_valid", 128'(out_valid), 128'(0));
        chk("str_end_ir", 128'(ir_out), 128'(NOP));
        chk("str_end_data", 128'(data_out), 128'(0));

        // backpressure: A, B accepted, C held upstream
        cyc();
        out_ready = 1'b0;
        drive(1'b1, 32'h0000_0A13, 32'hA);
        cyc();
        drive(1'b1, 32'h0000_0B13, 32'hB);
        smp();
        chk("bp_a_ready", 128'(in_ready), 128'(1));
        chk("bp_a_ir", 128'(ir_out), 128'(32'h0000_0A13));
        cyc();
        drive(1'b1, 32'h0000_0C13, 32'hC);
        smp();
        chk("bp_two_ready", 128'(in_ready), 128'(0));
        chk("bp_two_ir", 128'(ir_out), 128'(32'h0000_0A13));
        cyc();
        smp();
        chk("bp_hold_ready", 128'(in_ready), 128'(0));
        chk("bp_hold_ir", 128'(ir_out), 128'(32'h0000_0A13));
        out_ready = 1'b1;
        cyc();
        smp();
        chk("bp_b_ir", 128'(ir_out), 128'(32'h0000_0B13));
        chk("bp_b_ctl", 128'(ctl_out), 128'(32'hB));
        chk("bp_b_data", 128'(data_out), 128'({64'h0, 32'h0000_0B13}));
        chk("bp_b_ready", 128'(in_ready), 128'(1));
        cyc();
        drive(1'b0, 32'h0, 32'h0);
        smp();
        chk("bp_c_ir", 128'(ir_out), 128'(32'h0000_0C13));
        chk("bp_c_valid", 128'(out_valid), 128'(1));
        cyc();
        smp();
        chk("bp_end_valid", 128'(out_valid), 128'(0));

        // flush from TWO with a same-cycle input
        out_ready = 1'b0;
        drive(1'b1, 32'h0000_0D13, 32'hD);
        cyc();
        drive(1'b1, 32'h0000_0E13, 32'hE);
        cyc();
        smp();
        chk("fl_pre_ready", 128'(in_ready), 128'(0));
        flush = 1'b1;
        drive(1'b1, 32'h0040_0213, 32'h4);
        cyc();
        flush = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        smp();
        chk("fl_valid", 128'(out_valid), 128'(0));
        chk("fl_ir", 128'(ir_out), 128'(NOP));
        chk("fl_ctl", 128'(ctl_out), 128'(0));
        chk("fl_data", 128'(data_out), 128'(0));
        chk("fl_ready", 128'(in_ready), 128'(1));
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            smp();
            chk("fl_after_valid", 128'(out_valid), 128'(0));
        end

        // simultaneous accept/retire in ONE for 10 cycles
        drive(1'b1, 32'h0000_1000, 32'h100);
        cyc();
        for (int i = 1; i <= 10; i++) begin
            drive(1'b1, 32'h0000_1000 + 32'(i), 32'h100 + 32'(i));
            smp();
            chk("sim_ir", 128'(ir_out), 128'(32'h0000_1000 + 32'(i - 1)));
            chk("sim_ready", 128'(in_ready), 128'(1));
            chk("sim_valid", 128'(out_valid), 128'(1));
            cyc();
        end
        drive(1'b0, 32'h0, 32'h0);
        smp();
        chk("sim_last_ir", 128'(ir_out), 128'(32'h0000_100A));
        cyc();
        smp();
        chk("sim_end_valid", 128'(out_valid), 128'(0));

        // input changes with in_valid low have no effect
        drive(1'b0, 32'h1234_5678, 32'hFF);
        cyc();
        smp();
        chk("idle_valid", 128'(out_valid), 128'(0));
        chk("idle_ir", 128'(ir_out), 128'(NOP));

        // asynchronous reset mid-transfer discards entries
        out_ready = 1'b0;
        drive(1'b1, 32'h0000_0F13, 32'hF);
        cyc();
        drive(1'b1, 32'h0000_0F93, 32'hF);
        cyc();
        drive(1'b0, 32'h0, 32'h0);
        #2;
        rstn = 1'b0;
        #1;
        chk("arst_valid", 128'(out_valid), 128'(0));
        chk("arst_ready", 128'(in_ready), 128'(1));
        chk("arst_ir", 128'(ir_out), 128'(NOP));
`ifdef PIPE_STALL_CNT_EN
        chk("arst_stall", 128'(stall_cnt), 128'(0));
`endif
        cyc();
        rstn = 1'b1;
        cyc();

`ifdef PIPE_STALL_CNT_EN
        // stall counter: 7 stalled edges, then flush leaves it untouched
        out_ready = 1'b0;
        drive(1'b1, 32'h0000_5013, 32'h50);
        cyc();
        drive(1'b0, 32'h0, 32'h0);
        smp();
        chk("stall_start", 128'(stall_cnt), 128'(0));
        for (int i = 0; i < 7; i++) cyc();
        smp();
        chk("stall_seven", 128'(stall_cnt), 128'(7));
        out_ready = 1'b1;
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        smp();
        chk("stall_flush", 128'(stall_cnt), 128'(7));
        chk("stall_flush_valid", 128'(out_valid), 128'(0));
        cyc();
        smp();
        chk("stall_after", 128'(stall_cnt), 128'(7));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
